// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a CPU and a DMA requester.
// Each DMA transfer steals exactly one cycle from the CPU, which is stalled through cpu_en.
module mem_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_read,
  input  logic       cpu_write,
  input  logic [7:0] cpu_address,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  output logic       cpu_en,
  input  logic       dma_req,
  input  logic       dma_we,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  output logic       dma_ack,
  output logic [7:0] dma_rdata,
  output logic [7:0] mem_address,
  output logic       mem_write,
  output logic       mem_read,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_CPU = 2'd0,
    S_DMA = 2'd1,
    S_ACK = 2'd2
  } state_t;

  state_t state_r;

  // Ownership sequencing, DMA read capture and the one-cycle ack pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_CPU;
      dma_ack   <= 1'b0;
      dma_rdata <= 8'h00;
    end else begin
      case (state_r)
        S_CPU: begin
          state_r <= dma_req ? S_DMA : S_CPU;
          dma_ack <= 1'b0;
        end
        S_DMA: begin
          state_r <= S_ACK;
          dma_ack <= 1'b1;
          // DMA writes leave the last read result visible to the requester
          if (!dma_we) begin
            dma_rdata <= mem_rdata;
          end else begin
            dma_rdata <= dma_rdata;
          end
        end
        S_ACK: begin
          state_r <= S_CPU;
          dma_ack <= 1'b0;
        end
        default: begin
          state_r <= S_CPU;
          dma_ack <= 1'b0;
        end
      endcase
    end
  end

  // Memory port mux driven from registered state only, so dma_req never reaches mem_*
  always_comb begin
    if (rst) begin
      cpu_en      = 1'b1;
      mem_address = cpu_address;
      mem_write   = 1'b0;
      mem_read    = 1'b0;
      mem_wdata   = cpu_dout;
    end else if (state_r == S_DMA) begin
      cpu_en      = 1'b0;
      mem_address = dma_addr;
      mem_write   = dma_we;
      mem_read    = ~dma_we;
      mem_wdata   = dma_wdata;
    end else begin
      cpu_en      = 1'b1;
      mem_address = cpu_address;
      mem_write   = cpu_write;
      mem_read    = cpu_read;
      mem_wdata   = cpu_dout;
    end
  end

  assign cpu_din = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory, a tiny CPU model and
// an expected-read-data queue that is checked whenever the DUT acknowledges a DMA transfer.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_read, cpu_write;
  logic [7:0] cpu_address, cpu_dout, cpu_din;
  logic       cpu_en;
  logic       dma_req = 1'b0, dma_we = 1'b0;
  logic [7:0] dma_addr = 8'h00, dma_wdata = 8'h00;
  logic       dma_ack;
  logic [7:0] dma_rdata;
  logic [7:0] mem_address, mem_wdata, mem_rdata;
  logic       mem_write, mem_read;

  // directed CPU bus and program-driven CPU bus
  logic       d_read = 1'b0, d_write = 1'b0;
  logic [7:0] d_address = 8'h00, d_dout = 8'h00;
  logic       prog_run = 1'b0;
  logic [7:0] pc, r1;

  logic [7:0] mem [256];
  int         wcnt [256];
  logic [7:0] exp_q [$];
  int         errors = 0;
  int         checks = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_en(cpu_en),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_address(mem_address), .mem_write(mem_write), .mem_read(mem_read),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata   = mem[mem_address];
  assign cpu_read    = prog_run ? 1'b0 : d_read;
  assign cpu_write   = prog_run ? (pc == 8'd1) : d_write;
  assign cpu_address = prog_run ? 8'h80 : d_address;
  assign cpu_dout    = prog_run ? r1 : d_dout;

  always @(posedge clk) begin
    if (mem_write === 1'b1) begin
      mem[mem_address]  <= mem_wdata;
      wcnt[mem_address] <= wcnt[mem_address] + 1;
    end
  end

  // Program: 0: SET r1,0x33   1: STORE r1 -> [0x80]   2+: halt
  always @(posedge clk) begin
    if (rst) begin
      pc <= 8'd0;
      r1 <= 8'h00;
    end else if (prog_run && cpu_en) begin
      if (pc == 8'd0) begin
        r1 <= 8'h33;
        pc <= 8'd1;
      end else if (pc == 8'd1) begin
        pc <= 8'd2;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (dma_ack === 1'b1) begin
      check("ack_has_pending_request", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("dma_rdata_at_ack", 32'(dma_rdata), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_dma(input int ncyc, input logic [7:0] base,
                         output int acks, output int lows, output int maxrun);
    int run;
    int lim;
    logic [7:0] a;
    acks = 0; lows = 0; maxrun = 0; run = 0; a = base; lim = ncyc / 3;
    dma_we = 1'b0; dma_addr = a; dma_req = 1'b1;
    exp_q.push_back(mem[a]);
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (cpu_en === 1'b0) begin
        lows++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (dma_ack === 1'b1) begin
        acks++;
        if (acks < lim) begin
          a = a + 8'd1;
          dma_addr = a;
          exp_q.push_back(mem[a]);
        end else begin
          dma_req = 1'b0;
        end
      end
    end
    dma_req = 1'b0;
  endtask

  initial begin
    int acks, lows, maxrun;
    for (int i = 0; i < 256; i++) begin
      mem[i] <= 8'(i) ^ 8'hA5;
      wcnt[i] = 0;
    end
    #1;
    mem[8'h40] <= 8'h5A;
    mem[8'h20] <= 8'h00;
    mem[8'h21] <= 8'h00;
    mem[8'h80] <= 8'h00;

    // reset with CPU strobes active: strobes must be suppressed
    rst = 1'b1; d_write = 1'b1; d_read = 1'b1; d_address = 8'h10; d_dout = 8'hEE;
    tick();
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_cpu_en", 32'(cpu_en), 32'd1);
    tick();
    rst = 1'b0; d_write = 1'b0; d_read = 1'b0;
    check("rst_no_write_done", 32'(wcnt[8'h10]), 32'd0);
    tick();
    check("post_rst_ack", 32'(dma_ack), 32'd0);
    check("post_rst_rdata", 32'(dma_rdata), 32'h00);
    check("post_rst_cpu_en", 32'(cpu_en), 32'd1);

    // CPU pass-through read
    d_read = 1'b1; d_address = 8'h40;
    #1;
    check("cpu_rd_addr", 32'(mem_address), 32'h40);
    check("cpu_rd_strobe", 32'(mem_read), 32'd1);
    check("cpu_din", 32'(cpu_din), 32'h5A);
    tick();
    d_read = 1'b0; d_address = 8'h00;

    // DMA read of 0x40
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h40;
    exp_q.push_back(8'h5A);
    tick();
    check("dmard_cpu_en", 32'(cpu_en), 32'd0);
    check("dmard_addr", 32'(mem_address), 32'h40);
    check("dmard_read", 32'(mem_read), 32'd1);
    check("dmard_write", 32'(mem_write), 32'd0);
    check("dmard_no_ack_yet", 32'(dma_ack), 32'd0);
    tick();
    check("dmard_ack", 32'(dma_ack), 32'd1);
    check("dmard_rdata", 32'(dma_rdata), 32'h5A);
    check("dmard_ack_cpu_en", 32'(cpu_en), 32'd1);
    dma_req = 1'b0;
    tick();
    check("dmard_ack_one_cycle", 32'(dma_ack), 32'd0);
    check("dmard_rdata_held", 32'(dma_rdata), 32'h5A);
    tick();

    // CPU store and DMA write requested in the same cycle
    d_write = 1'b1; d_address = 8'h20; d_dout = 8'h11;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h21; dma_wdata = 8'h22;
    exp_q.push_back(8'h5A);
    tick();
    d_write = 1'b0;
    check("wr_cpu_first", 32'(mem[8'h20]), 32'h11);
    check("wr_dma_not_yet", 32'(mem[8'h21]), 32'h00);
    check("wr_dma_strobe", 32'(mem_write), 32'd1);
    tick();
    dma_req = 1'b0; dma_we = 1'b0;
    check("wr_dma_done", 32'(mem[8'h21]), 32'h22);
    check("wr_ack", 32'(dma_ack), 32'd1);
    tick();
    check("wr_cnt_20", 32'(wcnt[8'h20]), 32'd1);
    check("wr_cnt_21", 32'(wcnt[8'h21]), 32'd1);

    // continuous DMA reads for 30 cycles
    run_dma(30, 8'h00, acks, lows, maxrun);
    check("cont_acks", 32'(acks), 32'd10);
    check("cont_cpu_en_low", 32'(lows), 32'd10);
    check("cont_max_stall", 32'(maxrun), 32'd1);
    tick(); tick();
    check("cont_queue_drained", 32'(exp_q.size()), 32'd0);

    // CPU program under continuous DMA: STORE is stalled and replayed in the ack cycle
    prog_run = 1'b1;
    run_dma(12, 8'h60, acks, lows, maxrun);
    tick(); tick();
    check("prog_mem80", 32'(mem[8'h80]), 32'h33);
    check("prog_wcnt80", 32'(wcnt[8'h80]), 32'd1);
    check("prog_r1", 32'(r1), 32'h33);
    check("prog_pc", 32'(pc), 32'd2);
    check("prog_acks", 32'(acks), 32'd4);
    prog_run = 1'b0;

    // reset while in S_DMA aborts the transfer
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check("abort_pre_rdata", 32'(dma_rdata), 32'h00);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h40;
    tick();
    check("abort_in_dma", 32'(cpu_en), 32'd0);
    rst = 1'b1; dma_req = 1'b0;
    #1;
    check("abort_rst_read_forced", 32'(mem_read), 32'd0);
    check("abort_rst_cpu_en", 32'(cpu_en), 32'd1);
    tick();
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dma_ack === 1'b1) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    check("abort_rdata", 32'(dma_rdata), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
